// File: rtl/can_pkg.sv
// Shared CAN message types and field widths.
package can_pkg;

  localparam int CAN_ID_WIDTH   = 11;
  localparam int CAN_DLC_WIDTH  = 4;
  localparam int CAN_DATA_WIDTH = 64;

  typedef struct packed {
    logic [CAN_ID_WIDTH-1:0]   identifier;
    logic [CAN_DLC_WIDTH-1:0]  dlc;
    logic [CAN_DATA_WIDTH-1:0] data;
    logic                      frame_type;
  } can_msg_t;

endpackage

// File: rtl/tx_slot_select.sv
// Picks which of two slots to present: lowest identifier, slot 0 on a tie.
module tx_slot_select
  import can_pkg::*;
(
  input  logic [1:0]              valid,
  input  logic [CAN_ID_WIDTH-1:0] id0,
  input  logic [CAN_ID_WIDTH-1:0] id1,
  output logic                    sel
);

  always_comb begin
    sel = 1'b0;
    unique case (valid)
      2'b10:   sel = 1'b1;
      2'b11:   sel = (id1 < id0);
      default: sel = 1'b0;
    endcase
  end

endmodule

// File: rtl/tx_message_buffer.sv
// Two-slot CAN transmit buffer with priority selection, retries
// and abort handling.
module tx_message_buffer
  import can_pkg::*;
#(
  parameter int unsigned MAX_RETRIES = 8
)(
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      write_request,
  input  logic                      write_frame_type,
  input  logic [CAN_ID_WIDTH-1:0]   write_identifier,
  input  logic [CAN_DLC_WIDTH-1:0]  write_dlc,
  input  logic [CAN_DATA_WIDTH-1:0] write_data,
  input  logic                      abort_request,
  output logic                      write_accepted,
  output logic                      write_overflow,
  output logic                      buffer_full,
  output logic                      tx_request,
  output logic [CAN_ID_WIDTH-1:0]   tx_identifier,
  output logic [CAN_DLC_WIDTH-1:0]  tx_dlc,
  output logic [CAN_DATA_WIDTH-1:0] tx_data,
  output logic [0:0]                tx_frame_type,
  input  logic                      tx_start,
  input  logic                      tx_done,
  input  logic                      tx_arbitration_lost,
  input  logic                      tx_error,
  output logic                      tx_complete,
  output logic                      tx_failed,
  output logic                      tx_aborted
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQUEST,
    S_ACTIVE
  } tx_state_t;

  tx_state_t state_q, state_d;

  logic [1:0] valid_q, valid_d;
  can_msg_t   msg_q [2];
  can_msg_t   msg_d [2];
  logic [3:0] retry_q [2];
  logic [3:0] retry_d [2];
  logic       abort_q, abort_d;
  logic       act_q, sel_q, nsel;
  can_msg_t   fields_q;

  logic acc_d, ovf_d, cmp_d, fail_d, abt_d;
  logic pend, outcome;
  logic [3:0] retry_inc;
  can_msg_t   wmsg;

  assign outcome = tx_done | tx_error | tx_arbitration_lost;
  assign wmsg    = '{write_identifier, write_dlc,
                     write_data, write_frame_type};

  // Slot bookkeeping: frees from the current cycle land before the write
  always_comb begin
    valid_d   = valid_q;
    msg_d     = msg_q;
    retry_d   = retry_q;
    abort_d   = abort_q;
    acc_d     = 1'b0;
    ovf_d     = 1'b0;
    cmp_d     = 1'b0;
    fail_d    = 1'b0;
    abt_d     = 1'b0;
    pend      = abort_q | abort_request;
    retry_inc = retry_q[act_q] + 4'd1;
    unique case (state_q)
      S_ACTIVE: begin
        if (abort_request) valid_d[~act_q] = 1'b0;
        if (tx_done) begin
          valid_d[act_q] = 1'b0;
          cmp_d          = 1'b1;
          abort_d        = 1'b0;
        end else if (tx_error || tx_arbitration_lost) begin
          abort_d = 1'b0;
          if (pend) begin
            valid_d[act_q] = 1'b0;
            abt_d          = 1'b1;
          end else if (tx_error) begin
            retry_d[act_q] = retry_inc;
            if (retry_inc == 4'(MAX_RETRIES)) begin
              valid_d[act_q] = 1'b0;
              fail_d         = 1'b1;
            end
          end
        end else if (abort_request) begin
          abort_d = 1'b1;
        end
      end
      default: begin
        if (abort_request) begin
          valid_d = '0;
          abt_d   = 1'b1;
        end
      end
    endcase
    if (write_request) begin
      if (!valid_d[0]) begin
        valid_d[0] = 1'b1;
        msg_d[0]   = wmsg;
        retry_d[0] = '0;
        acc_d      = 1'b1;
      end else if (!valid_d[1]) begin
        valid_d[1] = 1'b1;
        msg_d[1]   = wmsg;
        retry_d[1] = '0;
        acc_d      = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // Selection looks at next-cycle slots so fields track tx_request
  tx_slot_select u_sel (
    .valid (valid_d),
    .id0   (msg_d[0].identifier),
    .id1   (msg_d[1].identifier),
    .sel   (nsel)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else if (!enable) state_q <= S_IDLE;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (|valid_d) state_d = S_REQUEST;
      end
      S_REQUEST: begin
        if (~|valid_d) state_d = S_IDLE;
        else if (tx_start && !abort_request) state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (outcome) state_d = (|valid_d) ? S_REQUEST : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_request    = (state_q == S_REQUEST);
    tx_identifier = fields_q.identifier;
    tx_dlc        = fields_q.dlc;
    tx_data       = fields_q.data;
    tx_frame_type = fields_q.frame_type;
    buffer_full   = &valid_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q        <= '0;
      msg_q[0]       <= '0;
      msg_q[1]       <= '0;
      retry_q[0]     <= '0;
      retry_q[1]     <= '0;
      abort_q        <= 1'b0;
      act_q          <= 1'b0;
      sel_q          <= 1'b0;
      fields_q       <= '0;
      write_accepted <= 1'b0;
      write_overflow <= 1'b0;
      tx_complete    <= 1'b0;
      tx_failed      <= 1'b0;
      tx_aborted     <= 1'b0;
    end else if (!enable) begin
      valid_q        <= '0;
      msg_q[0]       <= '0;
      msg_q[1]       <= '0;
      retry_q[0]     <= '0;
      retry_q[1]     <= '0;
      abort_q        <= 1'b0;
      act_q          <= 1'b0;
      sel_q          <= 1'b0;
      fields_q       <= '0;
      write_accepted <= 1'b0;
      write_overflow <= 1'b0;
      tx_complete    <= 1'b0;
      tx_failed      <= 1'b0;
      tx_aborted     <= 1'b0;
    end else begin
      valid_q        <= valid_d;
      msg_q[0]       <= msg_d[0];
      msg_q[1]       <= msg_d[1];
      retry_q[0]     <= retry_d[0];
      retry_q[1]     <= retry_d[1];
      abort_q        <= abort_d;
      write_accepted <= acc_d;
      write_overflow <= ovf_d;
      tx_complete    <= cmp_d;
      tx_failed      <= fail_d;
      tx_aborted     <= abt_d;
      if (state_q == S_REQUEST && state_d == S_ACTIVE)
        act_q <= sel_q;
      // Fields freeze during ACTIVE; re-pick whenever we will request
      if (state_d == S_REQUEST) begin
        sel_q    <= nsel;
        fields_q <= msg_d[nsel];
      end
    end
  end

endmodule

// File: tb/tb_tx_message_buffer.sv
// Directed and random stimulus against a slot-level reference model
// of the two-slot transmit buffer.
module tb_tx_message_buffer;

  localparam int MR = 3;

  logic        clock = 1'b0;
  logic        reset_n, enable;
  logic        write_request, write_frame_type;
  logic [10:0] write_identifier;
  logic [3:0]  write_dlc;
  logic [63:0] write_data;
  logic        abort_request;
  logic        write_accepted, write_overflow, buffer_full;
  logic        tx_request;
  logic [10:0] tx_identifier;
  logic [3:0]  tx_dlc;
  logic [63:0] tx_data;
  logic [0:0]  tx_frame_type;
  logic        tx_start, tx_done, tx_arbitration_lost, tx_error;
  logic        tx_complete, tx_failed, tx_aborted;

  tx_message_buffer #(.MAX_RETRIES(MR)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .write_request(write_request),
    .write_frame_type(write_frame_type),
    .write_identifier(write_identifier),
    .write_dlc(write_dlc), .write_data(write_data),
    .abort_request(abort_request),
    .write_accepted(write_accepted),
    .write_overflow(write_overflow),
    .buffer_full(buffer_full), .tx_request(tx_request),
    .tx_identifier(tx_identifier), .tx_dlc(tx_dlc),
    .tx_data(tx_data), .tx_frame_type(tx_frame_type),
    .tx_start(tx_start), .tx_done(tx_done),
    .tx_arbitration_lost(tx_arbitration_lost),
    .tx_error(tx_error), .tx_complete(tx_complete),
    .tx_failed(tx_failed), .tx_aborted(tx_aborted)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  task automatic check_eq(input string tag,
                          input logic [63:0] got,
                          input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: 0 idle, 1 request, 2 active
  bit          m_val [2];
  logic [10:0] m_id  [2];
  logic [3:0]  m_dlc [2];
  logic [63:0] m_dat [2];
  bit          m_ft  [2];
  int          m_ret [2];
  int          m_st, m_act, m_pres;
  bit          m_pend;
  bit e_acc, e_ovf, e_cmp, e_fail, e_abt;

  function automatic int pick();
    if (m_val[0] && m_val[1]) return (m_id[1] < m_id[0]) ? 1 : 0;
    return m_val[1] ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_val[i] = 0; m_id[i] = 0; m_dlc[i] = 0;
      m_dat[i] = 0; m_ft[i] = 0; m_ret[i] = 0;
    end
    m_st = 0; m_act = 0; m_pres = 0; m_pend = 0;
    {e_acc, e_ovf, e_cmp, e_fail, e_abt} = '0;
  endtask

  task automatic free_active(output bit freed);
    m_val[m_act] = 0;
    freed = 1;
  endtask

  task automatic model_step();
    bit any, outc, f;
    int slot;
    {e_acc, e_ovf, e_cmp, e_fail, e_abt} = '0;
    outc = tx_done | tx_error | tx_arbitration_lost;
    if (!enable) begin
      model_reset();
      return;
    end
    if (m_st == 2) begin
      if (abort_request) m_val[1 - m_act] = 0;
      if (tx_done) begin
        free_active(f); e_cmp = 1; m_pend = 0;
      end else if (tx_error || tx_arbitration_lost) begin
        if (m_pend || abort_request) begin
          free_active(f); e_abt = 1;
        end else if (tx_error) begin
          m_ret[m_act]++;
          if (m_ret[m_act] == MR) begin
            free_active(f); e_fail = 1;
          end
        end
        m_pend = 0;
      end else if (abort_request) m_pend = 1;
    end else if (abort_request) begin
      m_val[0] = 0; m_val[1] = 0; e_abt = 1;
    end
    if (write_request) begin
      slot = !m_val[0] ? 0 : (!m_val[1] ? 1 : -1);
      if (slot < 0) e_ovf = 1;
      else begin
        m_val[slot] = 1; m_id[slot] = write_identifier;
        m_dlc[slot] = write_dlc; m_dat[slot] = write_data;
        m_ft[slot] = write_frame_type; m_ret[slot] = 0;
        e_acc = 1;
      end
    end
    any = m_val[0] | m_val[1];
    if (m_st == 2) begin
      if (outc) m_st = any ? 1 : 0;
    end else if (!any) m_st = 0;
    else if (m_st == 1 && tx_start && !abort_request) begin
      m_st = 2; m_act = m_pres;
    end else m_st = 1;
    if (m_st == 1) m_pres = pick();
  endtask

  task automatic clear_inputs();
    write_request = 0; write_frame_type = 0;
    write_identifier = 0; write_dlc = 0; write_data = 0;
    abort_request = 0; tx_start = 0; tx_done = 0;
    tx_arbitration_lost = 0; tx_error = 0;
  endtask

  task automatic step();
    int s;
    @(posedge clock);
    model_step();
    #1;
    check_eq("write_accepted", write_accepted, e_acc);
    check_eq("write_overflow", write_overflow, e_ovf);
    check_eq("tx_complete", tx_complete, e_cmp);
    check_eq("tx_failed", tx_failed, e_fail);
    check_eq("tx_aborted", tx_aborted, e_abt);
    check_eq("buffer_full", buffer_full, m_val[0] & m_val[1]);
    check_eq("tx_request", tx_request, m_st == 1);
    if (m_st != 0) begin
      s = (m_st == 2) ? m_act : m_pres;
      check_eq("tx_identifier", tx_identifier, m_id[s]);
      check_eq("tx_dlc", tx_dlc, m_dlc[s]);
      check_eq("tx_data", tx_data, m_dat[s]);
      check_eq("tx_frame_type", tx_frame_type, m_ft[s]);
    end
    clear_inputs();
  endtask

  task automatic wr(input logic [10:0] id, input logic [3:0] dlc,
                    input logic [63:0] d, input logic ft);
    write_request = 1; write_identifier = id;
    write_dlc = dlc; write_data = d; write_frame_type = ft;
    step();
  endtask

  task automatic pulse_start();
    tx_start = 1; step();
  endtask

  initial begin
    clear_inputs();
    model_reset();
    enable = 1;
    reset_n = 0;
    repeat (2) @(posedge clock);
    #1;
    check_eq("reset_tx_request", tx_request, 0);
    check_eq("reset_buffer_full", buffer_full, 0);
    check_eq("reset_tx_identifier", tx_identifier, 0);
    reset_n = 1;

    // single message round trip
    wr(11'h123, 4'd8, 64'h0102030405060708, 0);
    check_eq("t1_accept", write_accepted, 1);
    check_eq("t1_req", tx_request, 1);
    check_eq("t1_id", tx_identifier, 11'h123);
    check_eq("t1_data", tx_data, 64'h0102030405060708);
    pulse_start();
    check_eq("t1_req_active", tx_request, 0);
    tx_done = 1; step();
    check_eq("t1_complete", tx_complete, 1);
    check_eq("t1_idle", tx_request, 0);

    // priority selection and overflow
    wr(11'h300, 4'd1, 64'h11, 0);
    wr(11'h100, 4'd2, 64'h22, 1);
    check_eq("t2_lowest_id", tx_identifier, 11'h100);
    wr(11'h050, 4'd3, 64'h33, 0);
    check_eq("t2_overflow", write_overflow, 1);
    check_eq("t2_full", buffer_full, 1);
    abort_request = 1; step();
    check_eq("t2_abort", tx_aborted, 1);
    check_eq("t2_empty", buffer_full, 0);

    // retries exhausted
    wr(11'h200, 4'd4, 64'h44, 0);
    for (int i = 0; i < MR; i++) begin
      pulse_start();
      tx_error = 1; step();
    end
    check_eq("t3_failed", tx_failed, 1);
    check_eq("t3_req_off", tx_request, 0);

    // arbitration loss never consumes retries
    wr(11'h210, 4'd5, 64'h55, 0);
    for (int i = 0; i < 20; i++) begin
      pulse_start();
      tx_arbitration_lost = 1; step();
      check_eq("t4_rereq", tx_request, 1);
    end
    for (int i = 0; i < MR - 1; i++) begin
      pulse_start();
      tx_error = 1; step();
      check_eq("t4_not_failed", tx_failed, 0);
    end
    pulse_start();
    tx_error = 1; step();
    check_eq("t4_failed", tx_failed, 1);

    // abort while a frame is on the bus
    wr(11'h010, 4'd1, 64'h66, 0);
    wr(11'h020, 4'd1, 64'h77, 0);
    pulse_start();
    abort_request = 1; step();
    check_eq("t5_other_freed", buffer_full, 0);
    check_eq("t5_no_pulse", tx_aborted, 0);
    tx_error = 1; step();
    check_eq("t5_aborted", tx_aborted, 1);
    check_eq("t5_idle", tx_request, 0);

    // enable low clears everything
    wr(11'h0AA, 4'd2, 64'h88, 1);
    enable = 0; step();
    enable = 1;
    check_eq("t6_en_req", tx_request, 0);
    check_eq("t6_en_id", tx_identifier, 0);

    // asynchronous reset during an active frame
    wr(11'h0BB, 4'd3, 64'h99, 0);
    pulse_start();
    #2 reset_n = 0;
    #1;
    model_reset();
    check_eq("t7_rst_id", tx_identifier, 0);
    check_eq("t7_rst_data", tx_data, 0);
    check_eq("t7_rst_full", buffer_full, 0);
    #4 reset_n = 1;
    tx_done = 1; step();
    check_eq("t7_done_ignored", tx_complete, 0);

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      write_request = ($urandom_range(0, 99) < 30);
      write_identifier = ($urandom_range(0, 1) == 1) ?
                         11'($urandom_range(0, 7)) :
                         11'($urandom_range(0, 2047));
      write_dlc = 4'($urandom_range(0, 15));
      write_data = {$urandom, $urandom};
      write_frame_type = 1'($urandom_range(0, 1));
      abort_request = ($urandom_range(0, 99) < 4);
      tx_start = ($urandom_range(0, 99) < 35);
      tx_done = ($urandom_range(0, 99) < 12);
      tx_error = ($urandom_range(0, 99) < 15);
      tx_arbitration_lost = ($urandom_range(0, 99) < 15);
      enable = ($urandom_range(0, 999) != 0);
      step();
      enable = 1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_message_buffer.md
TX_MESSAGE_BUFFER -- requirements
Module: tx_message_buffer

Interface
REQ-001 Parameter: MAX_RETRIES, 8, tx_error outcomes per slot before the message is dropped (range 1..15).
REQ-002 clock  in  1  rising-edge clock.
REQ-003 reset_n  in  1  reset, asynchronous, active-low.
REQ-004 enable  in  1  low = synchronous clear of all state and outputs to reset values.
REQ-005 write_request, write_frame_type  in  1 each  host write strobe and frame type (0 data, 1 remote).
REQ-006 write_identifier [10:0], write_dlc [3:0], write_data [63:0]  in  host message fields.
REQ-007 abort_request  in  1  host cancels all pending messages.
REQ-008 write_accepted, write_overflow  out  1 each  one-cycle pulses: write stored / write dropped.
REQ-009 buffer_full  out  1  both slots occupied.
REQ-010 tx_request  out  1  message presented to the transmitter.
REQ-011 tx_identifier [10:0], tx_dlc [3:0], tx_data [63:0], tx_frame_type [0:0]  out  selected slot contents.
REQ-012 tx_start, tx_done, tx_arbitration_lost, tx_error  in  1 each  transmitter pulses: frame begun, success, lost arbitration, bus error.
REQ-013 tx_complete, tx_failed, tx_aborted  out  1 each  one-cycle outcome pulses to host.

Function
REQ-014 The buffer SHALL hold two slots, each with valid bit, fields and a 4-bit retry counter.
REQ-015 A write SHALL store into the lowest-index free slot, clear its retry counter and pulse write_accepted the next cycle; a slot freed in the same cycle SHALL count as free.
REQ-016 A write with both slots valid SHALL be dropped and pulse write_overflow.
REQ-017 States: IDLE (no valid slot), REQUEST (tx_request=1), ACTIVE (frame in progress, tx_request=0).
REQ-018 In REQUEST, selection SHALL be re-evaluated every cycle: lowest identifier wins; on equal identifiers slot 0 wins.
REQ-019 tx_start in REQUEST SHALL freeze the selected slot and move to ACTIVE; tx_start in other states SHALL be ignored.
REQ-020 In ACTIVE, tx_done SHALL free the slot and pulse tx_complete.
REQ-021 In ACTIVE, tx_arbitration_lost SHALL return to REQUEST without changing the retry counter.
REQ-022 In ACTIVE, tx_error SHALL increment the slot retry counter; on reaching MAX_RETRIES, the slot SHALL be freed and tx_failed pulsed, otherwise the block SHALL return to REQUEST.
REQ-023 Simultaneous outcome pulses SHALL resolve with priority tx_done > tx_error > tx_arbitration_lost.
REQ-024 After any outcome, the next state SHALL be REQUEST if any slot is valid, else IDLE.
REQ-025 abort_request in IDLE/REQUEST SHALL free all slots and pulse tx_aborted (one pulse per abort_request cycle).
REQ-026 abort_request in ACTIVE SHALL set a pending-abort flag that frees the non-active slot immediately; the next tx_done SHALL still pulse tx_complete, tx_error/tx_arbitration_lost SHALL free the slot and pulse tx_aborted, and the flag SHALL then clear.
REQ-027 tx_* field outputs SHALL be registered and SHALL be stable while tx_request=1 or state is ACTIVE.

Reset
REQ-028 reset_n low or enable low SHALL clear all valid bits, retry counters, fields, the abort flag and every output to 0, with state IDLE.

Structure
REQ-029 A shared can_pkg package SHALL hold the message struct (identifier, dlc, data, frame_type) and CAN_ID_WIDTH=11, CAN_DLC_WIDTH=4, CAN_DATA_WIDTH=64.
REQ-030 The tx_state_t enum SHALL be local; a tx_slot_select combinational sub-module SHALL implement REQ-018.

Verification
REQ-031 Write id 0x123 dlc 8 data 0x0102030405060708 -> write_accepted next cycle, tx_request=1 with the same fields; tx_start then tx_done -> tx_complete pulse, IDLE.
REQ-032 Write id 0x300 then 0x100, no tx_start -> tx_identifier=0x100; third write -> write_overflow pulse, buffer_full=1.
REQ-033 MAX_RETRIES=3, three tx_start/tx_error pairs -> tx_failed after third error, slot freed, tx_request=0.
REQ-034 tx_start, tx_arbitration_lost repeated 20 times -> retry counter stays 0, tx_request reasserted each time.
REQ-035 Two slots valid, tx_start, abort_request, then tx_error -> other slot freed immediately, tx_aborted pulse on error, IDLE.
REQ-036 Assert reset_n low during ACTIVE -> all outputs 0 asynchronously; tx_done after reset ignored.
